rvfi_commit_checker_rv32imc: RTL and testbench
==============================================

# rvfi_commit_checker_rv32imc

Single-channel RVFI commit-stream checker for the RV32IMC out-of-order core, instantiated by the testbench monitor as `riscv_formal_monitor_rv32imc`. It observes one retirement per cycle and checks the stream for consistency. The checks cover order sequencing, PC continuity, register-value coherence against a shadow register file, x0 discipline, memory-mask legality and post-halt retirement. The first violation is reported as a sticky 16-bit error code, which the bench polls every cycle.

## Interface
- Parameters: none; single retirement channel (NRET=1), XLEN=32, ILEN=32.
- clock  in  1  sampling clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- rvfi_valid  in  1  a commit is presented this cycle.
- rvfi_order  in  64  retirement sequence number.
- rvfi_insn  in  32  instruction word; compressed instructions in [15:0].
- rvfi_trap / rvfi_halt / rvfi_intr  in  1 each  trap flag, halt flag, interrupt flag.
- rvfi_mode  in  2  privilege mode; ignored.
- rvfi_rs1_addr / rvfi_rs2_addr  in  5 each  source register indices.
- rvfi_rs1_rdata / rvfi_rs2_rdata  in  32 each  source register values.
- rvfi_rd_addr  in  5  destination register index.
- rvfi_rd_wdata  in  32  destination register value.
- rvfi_pc_rdata / rvfi_pc_wdata  in  32 each  PC of this instruction, and next PC.
- rvfi_mem_addr  in  32  word-aligned memory address.
- rvfi_mem_rmask / rvfi_mem_wmask  in  4 each  byte read mask, byte write mask.
- rvfi_mem_rdata / rvfi_mem_wdata  in  32 each  memory data read, memory data written.
- rvfi_mem_extamo  in  1  ignored.
- errcode  out  16  0 means no error; otherwise the code of the first detected violation.

## Operation
- **State**
  - expected order (64b) plus valid bit.
  - expected PC (32b) plus valid bit.
  - shadow register file x1..x31 (32b each) plus a per-register valid bit.
  - halted flag.
  - errcode register.
- **Checks**: evaluated only when rvfi_valid=1 and errcode=0. If several fail in one commit, the lowest code wins.
  - 1: rvfi_order differs from expected order, when expected order is valid.
  - 2: rvfi_pc_rdata differs from expected PC, when expected PC is valid.
  - 3: rvfi_pc_rdata[0] or rvfi_pc_wdata[0] is 1 (IALIGN=16).
  - 4: rs1_addr≠0 and shadow[rs1] is valid and rs1_rdata≠shadow[rs1]. Also fails if rs1_addr=0 and rs1_rdata≠0.
  - 5: the same rule as code 4, applied to rs2.
  - 6: rd_addr=0 and rd_wdata≠0.
  - 7: rmask or wmask not in {0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111}.
  - 8: rmask and wmask both nonzero.
  - 9: mem_addr[1:0]≠00 while either mask is nonzero.
  - 10: rvfi_trap=1 or rvfi_intr=1.
  - 11: commit while halted flag is set.
- **Updates** on every valid commit, regardless of check outcome:
  - expected order ← rvfi_order+1; set its valid bit.
  - expected PC ← rvfi_pc_wdata; set its valid bit.
  - if rd_addr≠0: shadow[rd] ← rd_wdata and set its valid bit.
- **Learning**: the first commit after reset establishes order and PC without checking them. Unwritten registers learn their value from the first read without a check.
- **Sticky errors**:
  - the first nonzero code is latched until reset; later violations do not overwrite it.
  - learning and updates continue after an error is latched.
- **Halt**: halted flag ← 1 at any rising edge where rvfi_halt=1, with or without valid. It is cleared only by reset.
- **Invalid cycles**: cycles with rvfi_valid=0 change nothing except the halted flag.

## Timing
- Reset (reset=0, asynchronous): errcode=0, all valid bits 0, halted=0. Effective immediately, including mid-stream.
- Latency: a violation on the commit sampled at edge N shows errcode≠0 after edge N, i.e. visible in cycle N+1.
- No handshake: a commit is accepted every cycle that rvfi_valid=1, including back-to-back commits.
- A rd write and a same-register read in one commit: the check uses the old shadow value, then the shadow is updated.
- Order arithmetic wraps modulo 2^64. The x0 shadow entry is never written.

## Test plan
- **Sequential stream**: orders 0,1,2 with PCs 0x60000000→0x60000004→0x60000006, consistent register data → errcode stays 0.
- **Order gap**: orders 5 then 7 → errcode=1 one cycle after the second commit; it remains 1 through later good commits.
- **PC break**: commit with pc_wdata=0x100, next commit with pc_rdata=0x104 → errcode=2.
- **Stale register**: commit writes x5=0xDEADBEEF; next commit reads rs1=x5 with rdata 0x0 → errcode=4. A same-cycle order mismatch instead yields 1.
- **Memory and x0**:
  - rd_addr=0 with rd_wdata=0x1 → errcode=6.
  - after reset, rmask=0110 → errcode=7.
  - after reset, rmask=0001 with wmask=0001 → errcode=8.
- **Halt and reset**:
  - rvfi_halt=1 for one edge, then a valid commit → errcode=11.
  - assert reset=0 asynchronously mid-cycle → errcode=0 immediately; the next commit with any order is accepted.

Source files
------------

// File: rtl/rvfi_commit_checker_rv32imc.sv
// rvfi_commit_checker_rv32imc
//
// Checks a single-channel RVFI retirement stream from the RV32IMC core.
// Each commit is checked against state learned from the commits before it:
// the retirement order, the PC chain, and a shadow copy of the register file.
// The commit is also checked for x0 discipline, legal memory masks,
// traps/interrupts and retirement after halt. The first violation is latched
// into errcode and held there until reset.
//
// Ports
//   clock            sampling clock, all state updates on the rising edge
//   reset            asynchronous, active-low; 0 clears all state
//   rvfi_*           RVFI commit signals (mode, insn, mem data, extamo unused)
//   errcode          0 = clean, otherwise the lowest code of the first bad commit

module rvfi_commit_checker_rv32imc (
    input  logic        clock,
    input  logic        reset,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [1:0]  rvfi_mode,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic [31:0] rvfi_mem_rdata,
    input  logic [31:0] rvfi_mem_wdata,
    input  logic        rvfi_mem_extamo,
    output logic [15:0] errcode
);

    logic [63:0] exp_order;
    logic        exp_order_valid;
    logic [31:0] exp_pc;
    logic        exp_pc_valid;
    logic [31:0] shadow [0:31];
    logic [31:0] shadow_valid;
    logic        halted;
    logic [15:0] check_code;
    logic        rs1_bad;
    logic        rs2_bad;
    logic        unused_inputs;

    assign unused_inputs = ^{rvfi_insn, rvfi_mode, rvfi_mem_addr[31:2],
                             rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_extamo};

    // Byte masks a 32-bit LSU can legally produce: byte, aligned half, word.
    function automatic logic mask_legal(input logic [3:0] m);
        case (m)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // x0 must read as zero; other registers are only compared once the
    // shadow copy holds a known value (written or learned from a read).
    assign rs1_bad = (rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != 32'd0)
                   : (shadow_valid[rvfi_rs1_addr] && (rvfi_rs1_rdata != shadow[rvfi_rs1_addr]));
    assign rs2_bad = (rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != 32'd0)
                   : (shadow_valid[rvfi_rs2_addr] && (rvfi_rs2_rdata != shadow[rvfi_rs2_addr]));

    // Evaluated from highest to lowest code so the lowest failing code is
    // the one left standing.
    always_comb begin
        check_code = 16'd0;
        if (halted)                                          check_code = 16'd11;
        if (rvfi_trap || rvfi_intr)                          check_code = 16'd10;
        if ((rvfi_mem_addr[1:0] != 2'b00) &&
            ((rvfi_mem_rmask != 4'd0) || (rvfi_mem_wmask != 4'd0)))
                                                             check_code = 16'd9;
        if ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0))
                                                             check_code = 16'd8;
        if (!mask_legal(rvfi_mem_rmask) || !mask_legal(rvfi_mem_wmask))
                                                             check_code = 16'd7;
        if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0))
                                                             check_code = 16'd6;
        if (rs2_bad)                                         check_code = 16'd5;
        if (rs1_bad)                                         check_code = 16'd4;
        if (rvfi_pc_rdata[0] || rvfi_pc_wdata[0])            check_code = 16'd3;
        if (exp_pc_valid && (rvfi_pc_rdata != exp_pc))       check_code = 16'd2;
        if (exp_order_valid && (rvfi_order != exp_order))    check_code = 16'd1;
    end

    // Control state: expectations, shadow valid bits, halt flag and the sticky
    // error code. Learning continues after an error has been latched so the
    // checker stays in step with the stream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_order       <= 64'd0;
            exp_order_valid <= 1'b0;
            exp_pc          <= 32'd0;
            exp_pc_valid    <= 1'b0;
            shadow_valid    <= 32'd0;
            halted          <= 1'b0;
            errcode         <= 16'd0;
        end else begin
            if (rvfi_halt)
                halted <= 1'b1;
            if (rvfi_valid) begin
                exp_order       <= rvfi_order + 64'd1;
                exp_order_valid <= 1'b1;
                exp_pc          <= rvfi_pc_wdata;
                exp_pc_valid    <= 1'b1;
                if (rvfi_rs1_addr != 5'd0)
                    shadow_valid[rvfi_rs1_addr] <= 1'b1;
                if (rvfi_rs2_addr != 5'd0)
                    shadow_valid[rvfi_rs2_addr] <= 1'b1;
                if (rvfi_rd_addr != 5'd0)
                    shadow_valid[rvfi_rd_addr] <= 1'b1;
                if ((errcode == 16'd0) && (check_code != 16'd0))
                    errcode <= check_code;
            end
        end
    end

    // Shadow data needs no reset: every entry is qualified by shadow_valid.
    // A read of an unknown register seeds it; a destination write comes
    // last so it wins over a same-commit read of the same register.
    always_ff @(posedge clock) begin
        if (rvfi_valid) begin
            if ((rvfi_rs1_addr != 5'd0) && !shadow_valid[rvfi_rs1_addr])
                shadow[rvfi_rs1_addr] <= rvfi_rs1_rdata;
            if ((rvfi_rs2_addr != 5'd0) && !shadow_valid[rvfi_rs2_addr])
                shadow[rvfi_rs2_addr] <= rvfi_rs2_rdata;
            if (rvfi_rd_addr != 5'd0)
                shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
        end
    end

endmodule

// File: tb/tb_rvfi_commit_checker_rv32imc.sv
// tb_rvfi_commit_checker_rv32imc
//
// Drives RVFI commits into rvfi_commit_checker_rv32imc. Each commit pushes
// the errcode expected after its sampling edge onto a scoreboard queue. A
// negedge process pops due entries and compares them against errcode.
// Asynchronous reset is checked directly, in the middle of a cycle.

module tb_rvfi_commit_checker_rv32imc;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_rdata;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic        trap;
        logic        intr;
        logic        halt;
    } commit_t;

    typedef struct {
        longint      due;
        logic [15:0] code;
        string       tag;
    } expect_t;

    logic        clock;
    logic        reset;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr;
    logic [4:0]  rvfi_rs2_addr;
    logic [31:0] rvfi_rs1_rdata;
    logic [31:0] rvfi_rs2_rdata;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_mem_wdata;
    logic        rvfi_mem_extamo;
    logic [15:0] errcode;

    int          assert_count;
    int          fail_count;
    longint      edge_count;
    expect_t     exp_q[$];

    rvfi_commit_checker_rv32imc dut (
        .clock           (clock),
        .reset           (reset),
        .rvfi_valid      (rvfi_valid),
        .rvfi_order      (rvfi_order),
        .rvfi_insn       (rvfi_insn),
        .rvfi_trap       (rvfi_trap),
        .rvfi_halt       (rvfi_halt),
        .rvfi_intr       (rvfi_intr),
        .rvfi_mode       (rvfi_mode),
        .rvfi_rs1_addr   (rvfi_rs1_addr),
        .rvfi_rs2_addr   (rvfi_rs2_addr),
        .rvfi_rs1_rdata  (rvfi_rs1_rdata),
        .rvfi_rs2_rdata  (rvfi_rs2_rdata),
        .rvfi_rd_addr    (rvfi_rd_addr),
        .rvfi_rd_wdata   (rvfi_rd_wdata),
        .rvfi_pc_rdata   (rvfi_pc_rdata),
        .rvfi_pc_wdata   (rvfi_pc_wdata),
        .rvfi_mem_addr   (rvfi_mem_addr),
        .rvfi_mem_rmask  (rvfi_mem_rmask),
        .rvfi_mem_wmask  (rvfi_mem_wmask),
        .rvfi_mem_rdata  (rvfi_mem_rdata),
        .rvfi_mem_wdata  (rvfi_mem_wdata),
        .rvfi_mem_extamo (rvfi_mem_extamo),
        .errcode         (errcode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_count <= edge_count + 1;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: compare every expectation whose edge has passed.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].due <= edge_count) begin
            expect_t e;
            e = exp_q.pop_front();
            check_output(e.tag, {48'd0, errcode}, {48'd0, e.code});
        end
    end

    function automatic commit_t mk(input logic [63:0] order, input logic [31:0] pc,
                                   input logic [31:0] npc);
        commit_t c;
        c = '0;
        c.valid    = 1'b1;
        c.order    = order;
        c.pc_rdata = pc;
        c.pc_wdata = npc;
        return c;
    endfunction

    task automatic drive(input commit_t c);
        rvfi_valid     = c.valid;
        rvfi_order     = c.order;
        rvfi_pc_rdata  = c.pc_rdata;
        rvfi_pc_wdata  = c.pc_wdata;
        rvfi_rs1_addr  = c.rs1_addr;
        rvfi_rs1_rdata = c.rs1_rdata;
        rvfi_rs2_addr  = c.rs2_addr;
        rvfi_rs2_rdata = c.rs2_rdata;
        rvfi_rd_addr   = c.rd_addr;
        rvfi_rd_wdata  = c.rd_wdata;
        rvfi_mem_addr  = c.mem_addr;
        rvfi_mem_rmask = c.rmask;
        rvfi_mem_wmask = c.wmask;
        rvfi_trap      = c.trap;
        rvfi_intr      = c.intr;
        rvfi_halt      = c.halt;
        rvfi_insn      = $urandom;
        rvfi_mode      = 2'(($urandom_range(0, 3)));
        rvfi_mem_rdata = $urandom;
        rvfi_mem_wdata = $urandom;
    endtask

    // Present one cycle of stimulus and queue the errcode expected after it.
    task automatic apply_stimulus(input string tag, input commit_t c,
                                  input logic [15:0] exp_code);
        expect_t e;
        @(posedge clock);
        #2;
        drive(c);
        e.due  = edge_count + 1;
        e.code = exp_code;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        commit_t idle;
        idle = '0;
        @(posedge clock);
        #2;
        drive(idle);
        @(negedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_output(tag, {48'd0, errcode}, 64'd0);
        exp_q.delete();
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        commit_t c;
        commit_t idle;
        assert_count = 0;
        fail_count   = 0;
        edge_count   = 0;
        idle         = '0;
        rvfi_mem_extamo = 1'b0;
        drive(idle);
        reset = 1'b0;
        #1;
        check_output("reset_state", {48'd0, errcode}, 64'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;

        // Sequential stream with consistent registers and a compressed step.
        c = mk(64'd0, 32'h6000_0000, 32'h6000_0004);
        c.rd_addr = 5'd1; c.rd_wdata = 32'h11;
        apply_stimulus("seq0", c, 16'd0);
        c = mk(64'd1, 32'h6000_0004, 32'h6000_0006);
        c.rs1_addr = 5'd1; c.rs1_rdata = 32'h11;
        c.rs2_addr = 5'd2; c.rs2_rdata = 32'h22;
        c.rd_addr  = 5'd3; c.rd_wdata  = 32'h33;
        c.mem_addr = 32'h100; c.rmask = 4'b1100;
        apply_stimulus("seq1", c, 16'd0);
        c = mk(64'd2, 32'h6000_0006, 32'h6000_000A);
        c.rs1_addr = 5'd2; c.rs1_rdata = 32'h22;
        c.rs2_addr = 5'd3; c.rs2_rdata = 32'h33;
        c.mem_addr = 32'h200; c.wmask = 4'b1111;
        apply_stimulus("seq2", c, 16'd0);
        apply_stimulus("seq_idle", idle, 16'd0);

        // Same-commit read and write: the read sees the old value.
        do_reset("reset_mid1");
        c = mk(64'd10, 32'h80, 32'h84); c.rd_addr = 5'd6; c.rd_wdata = 32'd1;
        apply_stimulus("rw0", c, 16'd0);
        c = mk(64'd11, 32'h84, 32'h88);
        c.rs1_addr = 5'd6; c.rs1_rdata = 32'd1; c.rd_addr = 5'd6; c.rd_wdata = 32'd2;
        apply_stimulus("rw1", c, 16'd0);
        c = mk(64'd12, 32'h88, 32'h8C); c.rs2_addr = 5'd6; c.rs2_rdata = 32'd2;
        apply_stimulus("rw2", c, 16'd0);

        // Order wraps modulo 2^64.
        do_reset("reset_mid2");
        apply_stimulus("wrap0", mk(64'hFFFF_FFFF_FFFF_FFFF, 32'h40, 32'h44), 16'd0);
        apply_stimulus("wrap1", mk(64'd0, 32'h44, 32'h48), 16'd0);

        // Order gap, then sticky through good and bad commits.
        do_reset("reset_mid3");
        apply_stimulus("gap0", mk(64'd5, 32'h1000, 32'h1004), 16'd0);
        apply_stimulus("gap1", mk(64'd7, 32'h1004, 32'h1008), 16'd1);
        apply_stimulus("gap_sticky", mk(64'd8, 32'h1008, 32'h100C), 16'd1);
        c = mk(64'd9, 32'h100C, 32'h1010); c.trap = 1'b1;
        apply_stimulus("gap_sticky_trap", c, 16'd1);

        // PC break.
        do_reset("reset_mid4");
        apply_stimulus("pc0", mk(64'd0, 32'h200, 32'h100), 16'd0);
        apply_stimulus("pc_break", mk(64'd1, 32'h104, 32'h108), 16'd2);

        // Stale register on rs1, then the same with an order slip too.
        do_reset("reset_mid5");
        c = mk(64'd0, 32'h1000, 32'h1004); c.rd_addr = 5'd5; c.rd_wdata = 32'hDEADBEEF;
        apply_stimulus("stale0", c, 16'd0);
        c = mk(64'd1, 32'h1004, 32'h1008); c.rs1_addr = 5'd5; c.rs1_rdata = 32'h0;
        apply_stimulus("stale_rs1", c, 16'd4);
        do_reset("reset_mid6");
        c = mk(64'd0, 32'h1000, 32'h1004); c.rd_addr = 5'd5; c.rd_wdata = 32'hDEADBEEF;
        apply_stimulus("prio0", c, 16'd0);
        c = mk(64'd3, 32'h1004, 32'h1008); c.rs1_addr = 5'd5; c.rs1_rdata = 32'h0;
        apply_stimulus("prio_order", c, 16'd1);

        // Stale register on rs2.
        do_reset("reset_mid7");
        c = mk(64'd0, 32'h300, 32'h304); c.rd_addr = 5'd7; c.rd_wdata = 32'd5;
        apply_stimulus("rs2_0", c, 16'd0);
        c = mk(64'd1, 32'h304, 32'h308); c.rs2_addr = 5'd7; c.rs2_rdata = 32'd6;
        apply_stimulus("stale_rs2", c, 16'd5);

        // Single-commit violations, each after a fresh reset.
        do_reset("reset_mid8");
        c = mk(64'd0, 32'h10, 32'h13);
        apply_stimulus("odd_pc", c, 16'd3);
        do_reset("reset_mid9");
        c = mk(64'd0, 32'h10, 32'h14); c.rs1_addr = 5'd0; c.rs1_rdata = 32'd5;
        apply_stimulus("x0_read", c, 16'd4);
        do_reset("reset_mid10");
        c = mk(64'd0, 32'h10, 32'h14); c.rd_addr = 5'd0; c.rd_wdata = 32'd1;
        apply_stimulus("x0_write", c, 16'd6);
        do_reset("reset_mid11");
        c = mk(64'd0, 32'h10, 32'h14); c.rmask = 4'b0110;
        apply_stimulus("bad_mask", c, 16'd7);
        do_reset("reset_mid12");
        c = mk(64'd0, 32'h10, 32'h14); c.rmask = 4'b0001; c.wmask = 4'b0001;
        apply_stimulus("rw_mask", c, 16'd8);
        do_reset("reset_mid13");
        c = mk(64'd0, 32'h10, 32'h14); c.rmask = 4'b1111; c.mem_addr = 32'h102;
        apply_stimulus("misaligned", c, 16'd9);
        do_reset("reset_mid14");
        c = mk(64'd0, 32'h10, 32'h14); c.intr = 1'b1;
        apply_stimulus("intr", c, 16'd10);

        // Halt without valid, then a commit; reset clears, any order accepted.
        do_reset("reset_mid15");
        c = idle; c.halt = 1'b1;
        apply_stimulus("halt_pulse", c, 16'd0);
        apply_stimulus("after_halt", mk(64'd0, 32'h20, 32'h24), 16'd11);
        do_reset("reset_clears_halt");
        apply_stimulus("post_reset", mk(64'd1234, 32'h40, 32'h44), 16'd0);
        apply_stimulus("final_idle", idle, 16'd0);

        repeat (4) @(negedge clock);
        #1;
        check_output("drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
